// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: raw buttons in, counter/display controls out.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       btn_load;
  logic       run;
  logic       tick;
  logic       load_n;
  logic       clr;
  logic       lap_latch;
  logic       freeze;
  logic [1:0] state;

  // Button source / output consumer side
  modport master (
    output btn_ss, btn_lap, btn_clr, btn_load,
    input  run, tick, load_n, clr, lap_latch, freeze, state
  );

  // Controller side
  modport slave (
    input  btn_ss, btn_lap, btn_clr, btn_load,
    output run, tick, load_n, clr, lap_latch, freeze, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button conditioning (sync, debounce, press
// detect), start/pause/lap/clear state machine and the run-gated tick divider.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int TICK_DIV  = 500000
) (
  input logic             i_clk,
  input logic             i_rst_n,
  stopwatch_ctrl_if.slave bus
);

  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Button slots: 0 = clear, 1 = start/stop, 2 = lap, 3 = load
  localparam int B_CLR  = 0;
  localparam int B_SS   = 1;
  localparam int B_LAP  = 2;
  localparam int B_LOAD = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  logic [3:0] w_btn_raw;
  logic [3:0] w_press;

  assign w_btn_raw = {bus.btn_load, bus.btn_lap, bus.btn_ss, bus.btn_clr};

  // Identical conditioning chain for every button
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_level;
      logic            r_level_d;
      logic [DB_W-1:0] r_cnt;

      // Two-flop synchroniser for the asynchronous raw button
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Accept a new level only after DB_CYCLES consecutive disagreeing samples
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (r_sync2 != r_level) begin
          if (r_cnt == DB_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      // Delayed debounced level for rising-edge (press) detection
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_level_d <= 1'b0;
        else          r_level_d <= r_level;
      end

      assign w_press[gi] = r_level & ~r_level_d;
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic             w_act_clr;
  logic             w_act_ss;
  logic             w_act_lap;
  logic             w_act_load;
  logic             w_run_next;
  logic             w_freeze_next;
  logic             w_clr_next;
  logic             w_lap_latch_next;
  logic             w_load_n_next;
  logic             r_run;
  logic             r_freeze;
  logic             r_clr;
  logic             r_lap_latch;
  logic             r_load_n;
  logic [DIV_W-1:0] r_div_cnt;

  // State and registered control outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_run       <= 1'b0;
      r_freeze    <= 1'b0;
      r_clr       <= 1'b0;
      r_lap_latch <= 1'b0;
      r_load_n    <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_run       <= w_run_next;
      r_freeze    <= w_freeze_next;
      r_clr       <= w_clr_next;
      r_lap_latch <= w_lap_latch_next;
      r_load_n    <= w_load_n_next;
    end
  end

  // Pick the highest-priority event legal in this state, then the next state
  always_comb begin
    w_act_clr    = 1'b0;
    w_act_ss     = 1'b0;
    w_act_lap    = 1'b0;
    w_act_load   = 1'b0;
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_PAUSE: begin
        if      (w_press[B_CLR])  w_act_clr  = 1'b1;
        else if (w_press[B_SS])   w_act_ss   = 1'b1;
        else if (w_press[B_LOAD]) w_act_load = 1'b1;
      end
      default: begin
        if      (w_press[B_SS])   w_act_ss   = 1'b1;
        else if (w_press[B_LAP])  w_act_lap  = 1'b1;
      end
    endcase
    case (r_state)
      S_IDLE:  if (w_act_ss)  w_state_next = S_RUN;
      S_RUN: begin
        if      (w_act_ss)  w_state_next = S_PAUSE;
        else if (w_act_lap) w_state_next = S_LAP;
      end
      S_LAP: begin
        if      (w_act_ss)  w_state_next = S_PAUSE;
        else if (w_act_lap) w_state_next = S_RUN;
      end
      S_PAUSE: begin
        if      (w_act_ss)  w_state_next = S_RUN;
        else if (w_act_clr) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of the control outputs; pulses follow the one-cycle press events
  always_comb begin
    w_run_next       = (w_state_next == S_RUN) || (w_state_next == S_LAP);
    w_freeze_next    = (w_state_next == S_LAP);
    w_clr_next       = w_act_clr;
    w_lap_latch_next = w_act_lap && (r_state == S_RUN);
    w_load_n_next    = ~w_act_load;
  end

  // Tick divider: advances only while running, holds while paused, clears with CLR
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
    end else if (w_act_clr) begin
      r_div_cnt <= '0;
    end else if (r_run) begin
      if (r_div_cnt == DIV_LAST) r_div_cnt <= '0;
      else                       r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign bus.run       = r_run;
  assign bus.tick      = r_run && (r_div_cnt == DIV_LAST);
  assign bus.load_n    = r_load_n;
  assign bus.clr       = r_clr;
  assign bus.lap_latch = r_lap_latch;
  assign bus.freeze    = r_freeze;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DB_CYCLES=4, TICK_DIV=5.
module tb_stopwatch_ctrl;

  localparam logic [3:0] B_CLR  = 4'b0001;
  localparam logic [3:0] B_SS   = 4'b0010;
  localparam logic [3:0] B_LAP  = 4'b0100;
  localparam logic [3:0] B_LOAD = 4'b1000;
  localparam int         NV     = 13;

  logic clk;
  logic rst_n;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .DB_CYCLES (4),
    .TICK_DIV  (5)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [3:0]  btn;
    logic [1:0]  st;
    logic        run;
    logic        frz;
    int          n_clr;
    int          n_latch;
    int          n_load;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor counters (written only by the monitor)
  int   c_clr = 0;
  int   c_latch = 0;
  int   c_load = 0;
  int   n_ticks = 0;
  int   bad_iv = 0;
  int   run_cnt = 0;

  // Pulse counting and tick-interval property: exactly 5 run cycles per tick
  always @(negedge clk) begin
    if (bus.clr)        c_clr   <= c_clr + 1;
    if (bus.lap_latch)  c_latch <= c_latch + 1;
    if (!bus.load_n)    c_load  <= c_load + 1;
    if (!rst_n) begin
      run_cnt <= 0;
    end else if (bus.clr) begin
      run_cnt <= 0;
    end else if (bus.tick) begin
      if (!bus.run || run_cnt != 4) bad_iv <= bad_iv + 1;
      run_cnt <= 0;
      n_ticks <= n_ticks + 1;
    end else if (bus.run) begin
      run_cnt <= run_cnt + 1;
    end
  end

  task automatic sb_push(input string n, input logic [31:0] e);
    sb_t it;
    it.name = n;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t it;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: got %0d with nothing expected", act);
    end else begin
      it = sb_q.pop_front();
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d", it.name, act, it.exp);
      end else begin
        $display("ok   %s = %0d", it.name, act);
      end
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {24'd0, bus.state, bus.run, bus.tick, bus.load_n, bus.clr,
            bus.lap_latch, bus.freeze};
  endfunction

  task automatic set_btn(input logic [3:0] b);
    {bus.btn_load, bus.btn_lap, bus.btn_ss, bus.btn_clr} = b;
  endtask

  vec_t        vecs[NV];
  vec_t        v;
  int          s_clr, s_latch, s_load, s_ticks;
  logic [1:0]  st6;
  logic [13:0] tmask;
  logic [2:0]  rmask;

  initial begin
    vecs[0]  = '{"lap_from_run",   B_LAP,          2'b11, 1'b1, 1'b1, 0, 1, 0};
    vecs[1]  = '{"clr_in_lap",     B_CLR,          2'b11, 1'b1, 1'b1, 0, 0, 0};
    vecs[2]  = '{"lap_in_lap",     B_LAP,          2'b01, 1'b1, 1'b0, 0, 0, 0};
    vecs[3]  = '{"clr_lap_run",    B_CLR | B_LAP,  2'b11, 1'b1, 1'b1, 0, 1, 0};
    vecs[4]  = '{"ss_in_lap",      B_SS,           2'b10, 1'b0, 1'b0, 0, 0, 0};
    vecs[5]  = '{"load_pause",     B_LOAD,         2'b10, 1'b0, 1'b0, 0, 0, 1};
    vecs[6]  = '{"lap_pause",      B_LAP,          2'b10, 1'b0, 1'b0, 0, 0, 0};
    vecs[7]  = '{"clr_load_pause", B_CLR | B_LOAD, 2'b00, 1'b0, 1'b0, 1, 0, 0};
    vecs[8]  = '{"load_idle",      B_LOAD,         2'b00, 1'b0, 1'b0, 0, 0, 1};
    vecs[9]  = '{"lap_idle",       B_LAP,          2'b00, 1'b0, 1'b0, 0, 0, 0};
    vecs[10] = '{"ss_load_idle",   B_SS | B_LOAD,  2'b01, 1'b1, 1'b0, 0, 0, 0};
    vecs[11] = '{"clr_ss_run",     B_CLR | B_SS,   2'b10, 1'b0, 1'b0, 0, 0, 0};
    vecs[12] = '{"clr_pause",      B_CLR,          2'b00, 1'b0, 1'b0, 1, 0, 0};

    // Reset state and quiet period
    rst_n = 1'b0;
    set_btn(4'b0000);
    sb_push("reset_outputs", 32'h08);
    repeat (3) @(posedge clk);
    #1;
    sb_check(outs());
    rst_n = 1'b1;
    s_ticks = n_ticks;
    sb_push("idle_state", 32'd0);
    sb_push("idle_run", 32'd0);
    sb_push("idle_load_n", 32'd1);
    sb_push("idle_ticks_50", 32'd0);
    clk_n(50);
    sb_check(32'(bus.state));
    sb_check(32'(bus.run));
    sb_check(32'(bus.load_n));
    sb_check(32'(n_ticks - s_ticks));

    // Start latency: raw rise after edge 0, RUN visible after edge 7
    clk_n(1);
    set_btn(B_SS);
    sb_push("ss_latency_state_e6", 32'd0);
    sb_push("ss_latency_state_e7", 32'd1);
    sb_push("ss_latency_run_e7", 32'd1);
    sb_push("tick_cadence_mask", 32'((14'd1 << 3) | (14'd1 << 8) | (14'd1 << 13)));
    st6 = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      clk_n(1);
      if (k == 6) st6 = bus.state;
    end
    sb_check(32'(st6));
    sb_check(32'(bus.state));
    sb_check(32'(bus.run));
    tmask = '0;
    for (int k = 8; k <= 21; k++) begin
      clk_n(1);
      tmask[k-8] = bus.tick;
      if (k == 10) set_btn(4'b0000);
    end
    sb_check(32'(tmask));
    sb_push("ss_held_no_second", 32'd1);
    clk_n(20);
    sb_check(32'(bus.state));

    // Short glitches on SS never pass the debouncer
    s_clr = c_clr; s_latch = c_latch; s_load = c_load;
    sb_push("glitch_state", 32'd1);
    sb_push("glitch_pulses", 32'd0);
    repeat (6) begin
      set_btn(B_SS);
      clk_n(3);
      set_btn(4'b0000);
      clk_n(1);
    end
    clk_n(12);
    sb_check(32'(bus.state));
    sb_check(32'((c_clr - s_clr) + (c_latch - s_latch) + (c_load - s_load)));

    // Table of single presses / simultaneous presses
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      s_clr = c_clr; s_latch = c_latch; s_load = c_load;
      sb_push({v.name, "_state"}, 32'(v.st));
      sb_push({v.name, "_run"}, 32'(v.run));
      sb_push({v.name, "_freeze"}, 32'(v.frz));
      sb_push({v.name, "_clr_cycles"}, 32'(v.n_clr));
      sb_push({v.name, "_latch_cycles"}, 32'(v.n_latch));
      sb_push({v.name, "_load_cycles"}, 32'(v.n_load));
      set_btn(v.btn);
      clk_n(6);
      set_btn(4'b0000);
      clk_n(12);
      sb_check(32'(bus.state));
      sb_check(32'(bus.run));
      sb_check(32'(bus.freeze));
      sb_check(32'(c_clr - s_clr));
      sb_check(32'(c_latch - s_latch));
      sb_check(32'(c_load - s_load));
    end

    // Pause with divider at 2, resume completes the partial period
    sb_push("pr_run_e7", 32'd1);
    sb_push("pr_state_e18", 32'd1);
    sb_push("pr_state_e19", 32'd2);
    sb_push("pr_paused_run_e36", 32'd0);
    sb_push("pr_resume_run_e37", 32'd1);
    sb_push("pr_resume_tick_mask", 32'b100);
    clk_n(1);
    set_btn(B_SS);
    clk_n(6);  set_btn(4'b0000);
    clk_n(1);  sb_check(32'(bus.run));
    clk_n(5);  set_btn(B_SS);
    clk_n(6);  set_btn(4'b0000);
    sb_check(32'(bus.state));
    clk_n(1);  sb_check(32'(bus.state));
    clk_n(11); set_btn(B_SS);
    clk_n(6);  set_btn(4'b0000);
    sb_check(32'(bus.run));
    rmask = '0;
    for (int k = 37; k <= 39; k++) begin
      clk_n(1);
      rmask[k-37] = bus.tick;
      if (k == 37) sb_check(32'(bus.run));
    end
    sb_check(32'(rmask));

    // Into LAP, then asynchronous reset mid-cycle
    clk_n(6);
    sb_push("lap_before_reset_freeze", 32'd1);
    sb_push("async_reset_outputs", 32'h08);
    sb_push("after_reset_state", 32'd0);
    sb_push("tick_interval_violations", 32'd0);
    set_btn(B_LAP);
    clk_n(6);
    set_btn(4'b0000);
    clk_n(4);
    sb_check(32'(bus.freeze));
    #3;
    rst_n = 1'b0;
    #1;
    sb_check(outs());
    clk_n(2);
    rst_n = 1'b1;
    clk_n(20);
    sb_check(32'(bus.state));
    sb_check(32'(bad_iv));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
